// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with hex / register-name glyphs,
// per-digit dot, blank and blink, and a double-buffered display set applied at frame wrap.
module seg_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     glyph_mode,
  input  logic [DIGITS-1:0]     dot_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  load,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     anode_n,
  output logic                  frame_tick
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PrescMax = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IdxMax   = IW'(DIGITS - 1);
  localparam logic [BW-1:0] FcntMax  = BW'(BLINK_DIV - 1);

  logic [PW-1:0]          presc_q;
  logic [IW-1:0]          idx_q;
  logic [BW-1:0]          fcnt_q;
  logic                   phase_q;

  logic [4*DIGITS-1:0]    pend_data_q, act_data_q;
  logic [DIGITS-1:0]      pend_mode_q, act_mode_q;
  logic [DIGITS-1:0]      pend_dot_q, act_dot_q;
  logic [DIGITS-1:0]      pend_blank_q, act_blank_q;
  logic [DIGITS-1:0]      pend_blink_q, act_blink_q;
  logic                   pend_valid_q;

  logic                   wrap;
  logic [3:0]             nib;
  logic [6:0]             glyph;
  logic                   dark;
  logic [7:0]             seg_d;
  logic [DIGITS-1:0]      anode_d;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;  4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;  4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;  4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;  4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;  4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;  4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;  4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;  default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] name_glyph(input logic [3:0] n);
    case (n)
      4'h0: name_glyph = 7'b0001000;  4'h1: name_glyph = 7'b0001110;
      4'h2: name_glyph = 7'b0000011;  4'h3: name_glyph = 7'b1000110;
      4'h4: name_glyph = 7'b0100001;  4'h5: name_glyph = 7'b0000110;
      4'h6: name_glyph = 7'b0001001;  4'h7: name_glyph = 7'b1000111;
      4'h8: name_glyph = 7'b0001100;  4'h9: name_glyph = 7'b1111001;
      4'hA: name_glyph = 7'b0000000;  4'hB: name_glyph = 7'b0010010;
      4'hC: name_glyph = 7'b1111000;  4'hD: name_glyph = 7'b1010001;
      4'hE: name_glyph = 7'b1011000;  default: name_glyph = 7'b1001110;
    endcase
  endfunction

  always_comb begin
    wrap  = (presc_q == PrescMax) && (idx_q == IdxMax);
    nib   = act_data_q[4*int'(idx_q) +: 4];
    glyph = act_mode_q[idx_q] ? name_glyph(nib) : hex_glyph(nib);
    dark  = act_blank_q[idx_q] | (act_blink_q[idx_q] & phase_q);
    // Segments are also blanked in the dead cycle so nothing leaks while anodes switch.
    seg_d = ((presc_q == '0) || dark) ? 8'hFF : {~act_dot_q[idx_q], glyph};
    anode_d = '1;
    if (presc_q != '0) anode_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      pend_data_q  <= '0;
      pend_mode_q  <= '0;
      pend_dot_q   <= '0;
      pend_blank_q <= '0;
      pend_blink_q <= '0;
      pend_valid_q <= 1'b0;
      act_data_q   <= '0;
      act_mode_q   <= '0;
      act_dot_q    <= '0;
      act_blank_q  <= '0;
      act_blink_q  <= '0;
      seg_out      <= 8'hFF;
      anode_n      <= '1;
      frame_tick   <= 1'b0;
    end else begin
      seg_out    <= seg_d;
      anode_n    <= anode_d;
      frame_tick <= wrap;

      if (presc_q == PrescMax) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IdxMax) ? '0 : idx_q + IW'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
      end

      if (wrap) begin
        if (fcnt_q == FcntMax) begin
          fcnt_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          fcnt_q <= fcnt_q + BW'(1);
        end
      end

      if (load) begin
        pend_data_q  <= digit_data;
        pend_mode_q  <= glyph_mode;
        pend_dot_q   <= dot_in;
        pend_blank_q <= blank;
        pend_blink_q <= blink;
      end

      // A load coincident with the wrap bypasses the pending set entirely.
      if (wrap) begin
        pend_valid_q <= 1'b0;
        if (load) begin
          act_data_q  <= digit_data;
          act_mode_q  <= glyph_mode;
          act_dot_q   <= dot_in;
          act_blank_q <= blank;
          act_blink_q <= blink;
        end else if (pend_valid_q) begin
          act_data_q  <= pend_data_q;
          act_mode_q  <= pend_mode_q;
          act_dot_q   <= pend_dot_q;
          act_blank_q <= pend_blank_q;
          act_blink_q <= pend_blink_q;
        end
      end else if (load) begin
        pend_valid_q <= 1'b1;
      end
    end
  end

endmodule
